fifo_status_arb: RTL and testbench
==================================

# fifo_status_arb

Multi-channel successor to the single-FIFO status controller. It watches the fill level of CH independent line/frame FIFOs, raises a burst or tail request when a channel crosses its threshold, and arbitrates the requests round-robin onto one shared request/response/done interface toward the AXI VDMA address engine. Each channel keeps its own frame-sync recovery and completion pulses. The block sits between the per-channel FIFO status outputs and the single read or write master.

## Interface
Parameters:
- CH, 2: number of channels (≥2); CHW = $clog2(CH).
- CW, 10: width of each count field.
- FULL_LEN, 256: FIFO depth in words.
- THRESHOLD, 200: READ requests when count < FULL_LEN-THRESHOLD; WRITE requests when count > THRESHOLD.
- BURST_LEN, 100: length issued for a normal burst.
- LSIZE, 9: width of request lengths.
- RST_WAIT, 31: consecutive fsync-low cycles required before a channel is re-armed.
- WR_RD, "READ": "READ" or "WRITE".
- MODE, "ONCE": "ONCE" = one tail per frame; "LINE" = a tail may follow any burst.

Ports:
- clock  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  CH  per-channel enable.
- count  in  CH*CW  channel i level in [i*CW +: CW].
- fsync  in  CH  per-channel frame sync / FIFO reset, level-sensitive.
- tail_status  in  CH  next transfer of the channel is a tail.
- tail_len  in  CH*LSIZE  tail length of channel i in [i*LSIZE +: LSIZE].
- req  out  1  request valid.
- req_ch  out  CHW  granted channel.
- req_len  out  LSIZE  request length.
- req_tail  out  1  request is a tail.
- resp  in  1  request accepted (1-cycle pulse).
- done  in  1  transfer complete (1-cycle pulse).
- burst_done  out  CH  1-cycle pulse per channel.
- tail_done  out  CH  1-cycle pulse per channel.
- busy  out  1  engine is not in ARB.

## Operation
Per-channel FSM, states WAIT_RST, IDLE, PEND, OWNED, FRAME_END:
- Reset: WAIT_RST with the wait counter at 0. While fsync[i]=1 the counter clears; otherwise it increments (saturating). When the counter reaches RST_WAIT the channel moves to IDLE.
- trig[i] is registered: enable[i] & level condition & !fsync[i]. The level comparison is unsigned, CW bits against a constant.
- IDLE & trig[i] → PEND.
- PEND & granted → OWNED.
- fsync[i] in IDLE or PEND → WAIT_RST; a pending request is dropped.
- OWNED exits when the engine finishes:
  - burst → IDLE.
  - tail with MODE="LINE" → IDLE.
  - tail with MODE="ONCE" → FRAME_END.
- FRAME_END & fsync[i] → WAIT_RST.
- fsync[i] while OWNED marks the channel aborted. It enters WAIT_RST when the engine releases it.

Shared engine FSM, states ARB, REQ, WAIT_DONE, FIN:
- ARB: if any channel is in PEND, pick the first PEND channel at or after ptr, scanning upward and wrapping modulo CH. On the grant, latch:
  - req_ch;
  - req_tail = tail_status[ch];
  - req_len = tail_len[ch] when the request is a tail, BURST_LEN otherwise.
  Then go to REQ and set ptr = ch+1 mod CH.
- REQ: req=1. resp → WAIT_DONE. fsync is ignored here except for marking the abort.
- WAIT_DONE: done → FIN. A done arriving during REQ is ignored.
- FIN: one cycle. Pulse burst_done[ch] or tail_done[ch] unless the channel is aborted; an aborted channel gets no pulse. Release the channel, then go to ARB.
- An aborted transfer still waits for done, so the master transaction is never orphaned.

## Timing
- Reset values: req, req_ch, req_len, req_tail, burst_done, tail_done, busy all 0; ptr=0; all channels in WAIT_RST.
- Trigger path: level true at edge t → trig at t+1 → PEND at t+2. If the engine is in ARB, req goes high at t+3.
- req drops on the edge after resp is sampled.
- The done pulse appears on the output 2 edges after done is sampled (WAIT_DONE→FIN, FIN registers the pulse).
- After FIN the engine returns to ARB, so a new grant can come 1 cycle after the done pulse.
- req_len, req_tail and req_ch are stable from the grant until FIN.
- Simultaneous PEND on several channels: strict round-robin, no starvation; each pending channel is served within CH grants.
- fsync on the granted channel in the same cycle as resp or done: the abort flag is set and the pulse is suppressed.
- Asynchronous rst mid-transfer returns everything to reset values immediately.

## Test plan
- Reset release, CH=2, fsync low: count[0]=10 (READ) → no req for 31 cycles; req=1, req_ch=0, req_len=100 at about cycle 34. resp, then done → burst_done[0] pulses once, 2 cycles after done.
- Both channels held below the threshold, ptr=0: grant order is 0,1,0,1 across four done handshakes; req_ch alternates with no repeats.
- tail_status[1]=1, tail_len=37, MODE="ONCE": req_tail=1, req_len=37 → tail_done[1] pulses; channel 1 stays silent despite its trigger until fsync[1] pulses and 31 quiet cycles pass.
- fsync[0] asserted in WAIT_DONE: req is not reissued, the engine still waits for done, and burst_done[0] stays 0. Channel 0 re-arms after RST_WAIT.
- WR_RD="WRITE", count=201 → request; count=200 → none. Also assert rst mid-REQ → all outputs are 0 in the same cycle.

Source files
------------

// File: rtl/fifo_status_arb.sv
// fifo_status_arb: per-channel FIFO level watchers arbitrated round-robin onto one request/response/done engine
// Ports:
//   clock_i, rst_i                 clock, asynchronous active-high reset
//   enable_i, fsync_i              per-channel enable and level-sensitive frame sync
//   count_i                        channel i fill level in [i*CW +: CW]
//   tail_status_i, tail_len_i      per-channel tail flag and tail length in [i*LSIZE +: LSIZE]
//   req_o, req_ch_o, req_len_o, req_tail_o   shared request toward the address engine
//   resp_i, done_i                 request accepted / transfer complete pulses
//   burst_done_o, tail_done_o      per-channel completion pulses
//   busy_o                         engine is not arbitrating
module fifo_status_arb #(
  parameter int CH = 2,
  parameter int CW = 10,
  parameter int FULL_LEN = 256,
  parameter int THRESHOLD = 200,
  parameter int BURST_LEN = 100,
  parameter int LSIZE = 9,
  parameter int RST_WAIT = 31,
  parameter string WR_RD = "READ",
  parameter string MODE = "ONCE",
  localparam int CHW = $clog2(CH)
) (
  input  logic                  clock_i,
  input  logic                  rst_i,
  input  logic [CH-1:0]         enable_i,
  input  logic [CH*CW-1:0]      count_i,
  input  logic [CH-1:0]         fsync_i,
  input  logic [CH-1:0]         tail_status_i,
  input  logic [CH*LSIZE-1:0]   tail_len_i,
  output logic                  req_o,
  output logic [CHW-1:0]        req_ch_o,
  output logic [LSIZE-1:0]      req_len_o,
  output logic                  req_tail_o,
  input  logic                  resp_i,
  input  logic                  done_i,
  output logic [CH-1:0]         burst_done_o,
  output logic [CH-1:0]         tail_done_o,
  output logic                  busy_o
);
  localparam int CNTW = $clog2(RST_WAIT + 1);
  localparam bit IS_RD = WR_RD == "READ";
  localparam bit ONCE = MODE == "ONCE";
  typedef enum logic [1:0] {ARB, REQ, WAIT_DONE, FIN} eng_t;
  typedef enum logic [2:0] {WAIT_RST, IDLE, PEND, OWNED, FRAME_END} ch_t;
  eng_t eng_q, eng_d;
  logic [CHW-1:0] ptr_q, ptr_d, req_ch_q, req_ch_d, gch;
  logic [LSIZE-1:0] req_len_q, req_len_d;
  logic req_tail_q, req_tail_d, found, fin;
  logic [CH-1:0] bd_q, bd_d, td_q, td_d, pend, abt, gnt;
  logic [LSIZE-1:0] tl [CH];
  assign fin = eng_q == FIN;
  // scan downward so the last hit is the first pending channel at or after ptr
  always_comb begin
    logic [CHW:0] s;
    found = 1'b0;
    gch = '0;
    s = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      s = {1'b0, ptr_q} + (CHW+1)'(k);
      s = s >= (CHW+1)'(CH) ? s - (CHW+1)'(CH) : s;
      if (pend[s[CHW-1:0]]) begin
        found = 1'b1;
        gch = s[CHW-1:0];
      end
    end
  end
  assign gnt = {CH{eng_q == ARB && found}} & (CH'(1) << gch);
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      eng_q <= ARB;
      ptr_q <= '0;
      req_ch_q <= '0;
      req_len_q <= '0;
      req_tail_q <= 1'b0;
      bd_q <= '0;
      td_q <= '0;
    end else begin
      eng_q <= eng_d;
      ptr_q <= ptr_d;
      req_ch_q <= req_ch_d;
      req_len_q <= req_len_d;
      req_tail_q <= req_tail_d;
      bd_q <= bd_d;
      td_q <= td_d;
    end
  end
  always_comb begin
    eng_d = eng_q;
    ptr_d = ptr_q;
    req_ch_d = req_ch_q;
    req_len_d = req_len_q;
    req_tail_d = req_tail_q;
    bd_d = '0;
    td_d = '0;
    case (eng_q)
      ARB: if (found) begin
        eng_d = REQ;
        req_ch_d = gch;
        req_tail_d = tail_status_i[gch];
        req_len_d = tail_status_i[gch] ? tl[gch] : LSIZE'(BURST_LEN);
        ptr_d = gch == CHW'(CH - 1) ? '0 : gch + CHW'(1);
      end
      REQ: eng_d = resp_i ? WAIT_DONE : REQ;
      WAIT_DONE: eng_d = done_i ? FIN : WAIT_DONE;
      default: begin
        eng_d = ARB;
        bd_d[req_ch_q] = !req_tail_q && !abt[req_ch_q];
        td_d[req_ch_q] = req_tail_q && !abt[req_ch_q];
      end
    endcase
  end
  always_comb begin
    req_o = eng_q == REQ;
    busy_o = eng_q != ARB;
  end
  assign req_ch_o = req_ch_q;
  assign req_len_o = req_len_q;
  assign req_tail_o = req_tail_q;
  assign burst_done_o = bd_q;
  assign tail_done_o = td_q;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    ch_t st_q, st_d;
    logic [CNTW-1:0] wc_q, wc_d;
    logic ab_q, ab_d, trig_q, lvl, rel;
    logic [CW-1:0] cnt;
    assign cnt = count_i[i*CW +: CW];
    assign lvl = IS_RD ? cnt < CW'(FULL_LEN - THRESHOLD) : cnt > CW'(THRESHOLD);
    assign tl[i] = tail_len_i[i*LSIZE +: LSIZE];
    // a channel seeing fsync this cycle is not offered to the arbiter, so a drop and a grant never coincide
    assign pend[i] = st_q == PEND && !fsync_i[i];
    assign abt[i] = ab_q || fsync_i[i];
    assign rel = fin && req_ch_q == CHW'(i);
    always_ff @(posedge clock_i or posedge rst_i) begin
      if (rst_i) begin
        st_q <= WAIT_RST;
        wc_q <= '0;
        ab_q <= 1'b0;
        trig_q <= 1'b0;
      end else begin
        st_q <= st_d;
        wc_q <= wc_d;
        ab_q <= ab_d;
        trig_q <= enable_i[i] && lvl && !fsync_i[i];
      end
    end
    always_comb begin
      st_d = st_q;
      wc_d = wc_q;
      ab_d = ab_q;
      case (st_q)
        WAIT_RST: begin
          st_d = !fsync_i[i] && wc_q == CNTW'(RST_WAIT) ? IDLE : WAIT_RST;
          wc_d = fsync_i[i] ? '0 : wc_q == CNTW'(RST_WAIT) ? wc_q : wc_q + 1'b1;
        end
        IDLE: begin
          st_d = fsync_i[i] ? WAIT_RST : trig_q ? PEND : IDLE;
          wc_d = '0;
        end
        PEND: begin
          st_d = fsync_i[i] ? WAIT_RST : gnt[i] ? OWNED : PEND;
          wc_d = '0;
        end
        OWNED: begin
          ab_d = rel ? 1'b0 : abt[i];
          wc_d = '0;
          st_d = !rel ? OWNED : abt[i] ? WAIT_RST : req_tail_q && ONCE ? FRAME_END : IDLE;
        end
        FRAME_END: begin
          st_d = fsync_i[i] ? WAIT_RST : FRAME_END;
          wc_d = '0;
        end
        default: st_d = WAIT_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_status_arb.sv
// tb_fifo_status_arb: directed bench for the multi-channel FIFO status arbiter
module tb_fifo_status_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, resp, done;
  logic [1:0] enable, fsync, tail_status;
  logic [19:0] count;
  logic [17:0] tail_len;
  logic req, req_tail, busy, wreq, wreq_tail, wbusy;
  logic [0:0] req_ch, wreq_ch, ch, exp_ch;
  logic [8:0] req_len, wreq_len;
  logic [1:0] bd, td, wbd, wtd;
  int checks = 0;
  int failures = 0;
  bit ok, seen;
  fifo_status_arb dut (
    .clock_i(clk), .rst_i(rst), .enable_i(enable), .count_i(count), .fsync_i(fsync),
    .tail_status_i(tail_status), .tail_len_i(tail_len), .req_o(req), .req_ch_o(req_ch),
    .req_len_o(req_len), .req_tail_o(req_tail), .resp_i(resp), .done_i(done),
    .burst_done_o(bd), .tail_done_o(td), .busy_o(busy)
  );
  fifo_status_arb #(.WR_RD("WRITE")) dutw (
    .clock_i(clk), .rst_i(rst), .enable_i(enable), .count_i(count), .fsync_i(fsync),
    .tail_status_i(tail_status), .tail_len_i(tail_len), .req_o(wreq), .req_ch_o(wreq_ch),
    .req_len_o(wreq_len), .req_tail_o(wreq_tail), .resp_i(resp), .done_i(done),
    .burst_done_o(wbd), .tail_done_o(wtd), .busy_o(wbusy)
  );
  task automatic wait_req(input int n, output bit got);
    got = req;
    for (int k = 0; k < n && !got; k++) begin
      @(negedge clk);
      got = req;
    end
  endtask
  task automatic reset_dut;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic serve(output logic [0:0] c, output bit got);
    wait_req(60, got);
    c = req_ch;
    if (got) begin
      resp = 1'b1;
      @(negedge clk);
      resp = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    enable = 2'b01; count = {10'd100, 10'd10}; fsync = 2'b00;
    tail_status = 2'b00; tail_len = '0; resp = 1'b0; done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req, req_ch, req_len, req_tail, bd, td, busy} !== 17'h0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0", {req, req_ch, req_len, req_tail, bd, td, busy});
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (31) begin @(negedge clk); seen |= req; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rst_wait_quiet got=%0b exp=0", seen); end
    wait_req(10, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", ok); end
    checks++;
    if (req_ch !== 1'b0) begin failures++; $display("FAIL first_req_ch got=%0h exp=0", req_ch); end
    checks++;
    if (req_len !== 9'd100) begin failures++; $display("FAIL first_req_len got=%0d exp=100", req_len); end
    checks++;
    if (req_tail !== 1'b0) begin failures++; $display("FAIL first_req_tail got=%0b exp=0", req_tail); end
  endtask
  task automatic test_burst;
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    checks++;
    if (req !== 1'b0) begin failures++; $display("FAIL req_drop got=%0b exp=0", req); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_wait got=%0b exp=1", busy); end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (bd !== 2'b00) begin failures++; $display("FAIL bd_early got=%0b exp=00", bd); end
    @(negedge clk);
    checks++;
    if (bd !== 2'b01) begin failures++; $display("FAIL bd_pulse got=%0b exp=01", bd); end
    checks++;
    if (td !== 2'b00) begin failures++; $display("FAIL td_on_burst got=%0b exp=00", td); end
    @(negedge clk);
    checks++;
    if (bd !== 2'b00) begin failures++; $display("FAIL bd_once got=%0b exp=00", bd); end
  endtask
  task automatic test_round_robin;
    enable = 2'b11; count = {10'd10, 10'd10};
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      serve(ch, ok);
      exp_ch = k[0];
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL rr_served[%0d] got=%0b exp=1", k, ok); end
      checks++;
      if (ch !== exp_ch) begin failures++; $display("FAIL rr_order[%0d] got=%0h exp=%0h", k, ch, exp_ch); end
    end
  endtask
  task automatic test_tail_once;
    enable = 2'b10; count = {10'd10, 10'd100}; tail_status = 2'b10; tail_len = {9'd37, 9'd0};
    reset_dut();
    wait_req(45, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL tail_req got=%0b exp=1", ok); end
    checks++;
    if ({req_ch, req_tail, req_len} !== {1'b1, 1'b1, 9'd37}) begin
      failures++; $display("FAIL tail_fields got=ch%0h/t%0b/len%0d exp=ch1/t1/len37", req_ch, req_tail, req_len);
    end
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    checks++;
    if ({td, bd} !== 4'b1000) begin failures++; $display("FAIL tail_pulse got=td%0b/bd%0b exp=td10/bd00", td, bd); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= req; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL frame_end_silent got=%0b exp=0", seen); end
    fsync = 2'b10;
    @(negedge clk);
    fsync = 2'b00;
    seen = 1'b0;
    repeat (31) begin @(negedge clk); seen |= req; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rearm_quiet got=%0b exp=0", seen); end
    wait_req(10, ok);
    checks++;
    if ({ok, req_ch} !== 2'b11) begin failures++; $display("FAIL rearm_req got=ok%0b/ch%0h exp=ok1/ch1", ok, req_ch); end
  endtask
  task automatic test_abort;
    enable = 2'b01; count = {10'd100, 10'd10}; tail_status = 2'b00;
    reset_dut();
    wait_req(45, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL abort_req got=%0b exp=1", ok); end
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    fsync = 2'b01;
    repeat (3) @(negedge clk);
    fsync = 2'b00;
    checks++;
    if (req !== 1'b0) begin failures++; $display("FAIL abort_no_reissue got=%0b exp=0", req); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_waits_done got=%0b exp=1", busy); end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= |{bd, td}; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_pulse got=%0b exp=0", seen); end
    seen = 1'b0;
    repeat (25) begin @(negedge clk); seen |= req; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_quiet got=%0b exp=0", seen); end
    wait_req(20, ok);
    checks++;
    if ({ok, req_ch} !== 2'b10) begin failures++; $display("FAIL abort_rearm got=ok%0b/ch%0h exp=ok1/ch0", ok, req_ch); end
  endtask
  task automatic test_write;
    enable = 2'b11; count = {10'd200, 10'd200}; tail_status = 2'b00;
    reset_dut();
    seen = 1'b0;
    repeat (45) begin @(negedge clk); seen |= wreq; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL wr_at_threshold got=%0b exp=0", seen); end
    count[9:0] = 10'd201;
    ok = wreq;
    for (int k = 0; k < 10 && !ok; k++) begin @(negedge clk); ok = wreq; end
    checks++;
    if ({ok, wreq_ch, wreq_len} !== {1'b1, 1'b0, 9'd100}) begin
      failures++; $display("FAIL wr_above got=ok%0b/ch%0h/len%0d exp=ok1/ch0/len100", ok, wreq_ch, wreq_len);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wreq, wreq_ch, wreq_len, wreq_tail, wbd, wtd, wbusy} !== 17'h0) begin
      failures++; $display("FAIL async_rst got=%0h exp=0", {wreq, wreq_ch, wreq_len, wreq_tail, wbd, wtd, wbusy});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_burst();
    test_round_robin();
    test_tail_once();
    test_abort();
    test_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
